nonce_sweeper: RTL and testbench

Upstream sequencer for the double-SHA256 miner core. Holds an 80-byte block-header template and substitutes successive 32-bit nonces into it. Presents each candidate header to the miner core and waits for the core's computed hash. Compares that hash against a 256-bit difficulty target and reports the first winning nonce, or reports that the nonce range is exhausted.

---
 rtl/nonce_sweeper.sv | 164 ++++++++++++++++
 tb/tb_nonce_sweeper.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweeper.sv
// Nonce sweeper: substitutes successive nonces into a header template, issues each to the
// miner core, and compares the returned hash against a target. Option macro: HASH_TIMEOUT_EN.
module nonce_sweeper #(
   parameter logic [31:0] NONCE_START    = 32'h0000_0000,
   parameter logic [31:0] NONCE_END      = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [639:0] header_template,
   input  logic [255:0] target,
   input  logic         hash_valid,
   input  logic [255:0] computed_hash,
   output logic [639:0] header,
   output logic         hash_start,
   output logic         busy,
   output logic         found,
   output logic         exhausted,
   output logic [31:0]  found_nonce,
   output logic [31:0]  current_nonce,
   output logic         timeout
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} stateT;

   stateT          state, stateNext;
   logic [31:0]    nonce;
   logic           headerLoaded;
   logic [607:0]   templateHi;
   logic [255:0]   targetReg;
   logic [255:0]   hashP1;
   logic           hit;
   logic           wdExpire;
   logic           unusedBits;

   // Core emits the digest in raw byte order; byte 0 is the most significant for comparison.
   function automatic logic [255:0] byteReverse(input logic [255:0] h);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = h[8*(31-i) +: 8];
      return r;
   endfunction

   assign hit           = (byteReverse(hashP1) <= targetReg);
   assign current_nonce = nonce;
   assign header        = headerLoaded ? {templateHi, nonce} : '0;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE, DONE: if (start) stateNext = ISSUE;
         ISSUE:      stateNext = WAIT;
         WAIT: begin
            if (hash_valid)    stateNext = CHECK;
            else if (wdExpire) stateNext = DONE;
         end
         CHECK: begin
            if (hit || nonce == NONCE_END) stateNext = DONE;
            else                           stateNext = ISSUE;
         end
         default:    stateNext = IDLE;
      endcase
      if (abort) stateNext = IDLE;
   end

   always_comb begin
      hash_start = 1'b0;
      busy       = 1'b0;
      unique case (state)
         ISSUE:       begin hash_start = 1'b1; busy = 1'b1; end
         WAIT, CHECK: busy = 1'b1;
         default:     ;
      endcase
   end

   // Control and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         headerLoaded <= 1'b0;
         nonce        <= NONCE_START;
         found        <= 1'b0;
         exhausted    <= 1'b0;
         found_nonce  <= '0;
      end else if (abort) begin
         found        <= 1'b0;
         exhausted    <= 1'b0;
         found_nonce  <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  headerLoaded <= 1'b1;
                  nonce        <= NONCE_START;
                  found        <= 1'b0;
                  exhausted    <= 1'b0;
               end
            end
            CHECK: begin
               if (hit) begin
                  found       <= 1'b1;
                  found_nonce <= nonce;
               end else if (nonce == NONCE_END) begin
                  exhausted   <= 1'b1;
               end else begin
                  nonce       <= nonce + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath captures need no reset: headerLoaded masks the header until first start
   always_ff @(posedge clk) begin
      if ((state == IDLE || state == DONE) && start && !abort) begin
         templateHi <= header_template[639:32];
         targetReg  <= target;
      end
      if (state == WAIT && hash_valid) hashP1 <= computed_hash;
   end

`ifdef HASH_TIMEOUT_EN
   logic [31:0] wdCount;
   logic        timeoutFlag;

   assign wdExpire = (wdCount == 32'(TIMEOUT_CYCLES - 1));
   assign timeout  = timeoutFlag;

   // Counter is zeroed in ISSUE, which always immediately precedes WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         wdCount     <= '0;
         timeoutFlag <= 1'b0;
      end else if (abort) begin
         timeoutFlag <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: if (start) timeoutFlag <= 1'b0;
            ISSUE:      wdCount <= '0;
            WAIT: begin
               if (!hash_valid) begin
                  if (wdExpire) timeoutFlag <= 1'b1;
                  else          wdCount     <= wdCount + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign unusedBits = ^header_template[31:0];
`else
   assign wdExpire   = 1'b0;
   assign timeout    = 1'b0;
   assign unusedBits = ^{header_template[31:0], TIMEOUT_CYCLES};
`endif

endmodule

// File: tb/tb_nonce_sweeper.sv
// Directed bench for nonce_sweeper: reset, sweep-to-hit, cadence, compare boundary,
// range exhaustion, abort racing hash_valid, and (with HASH_TIMEOUT_EN) the watchdog.
module tb_nonce_sweeper;

   localparam logic [255:0] HIT1  = 256'h01 << 248;  // reversed value 1
   localparam logic [255:0] EQFF  = 256'hFF << 248;  // reversed value 0xFF
   localparam logic [255:0] PLUS1 = 256'h01 << 240;  // reversed value 0x100
   localparam logic [255:0] MISS  = 256'hFF;         // reversed value 0xFF00..00

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, abort, hashValidA, hashValidB;
   logic [639:0] tmpl;
   logic [255:0] target, hash;

   logic [639:0] headerA, headerB;
   logic         hsA, hsB, busyA, busyB, foundA, foundB, exhA, exhB, toA, toB;
   logic [31:0]  fnA, fnB, cnA, cnB;

   int checks = 0;
   int errors = 0;
   int pulsesA = 0;
   int pulsesB = 0;
   logic [31:0] seen;

   nonce_sweeper #(.TIMEOUT_CYCLES(16)) dutA (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .header_template(tmpl), .target(target),
      .hash_valid(hashValidA), .computed_hash(hash),
      .header(headerA), .hash_start(hsA), .busy(busyA), .found(foundA),
      .exhausted(exhA), .found_nonce(fnA), .current_nonce(cnA), .timeout(toA)
   );

   nonce_sweeper #(.NONCE_START(32'hFFFF_FFFE), .NONCE_END(32'hFFFF_FFFF)) dutB (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .header_template(tmpl), .target(target),
      .hash_valid(hashValidB), .computed_hash(hash),
      .header(headerB), .hash_start(hsB), .busy(busyB), .found(foundB),
      .exhausted(exhB), .found_nonce(fnB), .current_nonce(cnB), .timeout(toB)
   );

   task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (hsA) pulsesA++;
      if (hsB) pulsesB++;
   endtask

   // Core model: wait for the issue pulse, hold two WAIT cycles, then return hash h
   task automatic serve(input bit useB, input logic [255:0] h, output logic [31:0] nonceSeen);
      int n = 0;
      while (!(useB ? hsB : hsA) && n < 20) begin
         step();
         n++;
      end
      checkEq("hash_start seen", useB ? hsB : hsA, 1);
      nonceSeen = useB ? headerB[31:0] : headerA[31:0];
      step();
      step();
      checkEq("header stable in wait", useB ? headerB[31:0] : headerA[31:0], nonceSeen);
      hash = h;
      if (useB) hashValidB = 1'b1;
      else      hashValidA = 1'b1;
      step();
      hashValidA = 1'b0;
      hashValidB = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; hashValidA = 1'b0; hashValidB = 1'b0;
      tmpl = {{19{32'h1234_5678}}, 32'hCAFE_F00D};
      target = '0; hash = '0;
      step(); step();
      rst = 1'b0;
      step();

      // Reset state
      checkEq("rst hash_start", hsA, 0);
      checkEq("rst busy", busyA, 0);
      checkEq("rst found", foundA, 0);
      checkEq("rst exhausted", exhA, 0);
      checkEq("rst found_nonce", fnA, 0);
      checkEq("rst current_nonce", cnA, 0);
      checkEq("rst header", headerA, 0);
      checkEq("rst current_nonce B", cnB, 32'hFFFF_FFFE);

      // Reset mid-WAIT
      start = 1'b1; step(); start = 1'b0;
      checkEq("issue pulse", hsA, 1);
      step();
      checkEq("wait busy", busyA, 1);
      rst = 1'b1; step(); rst = 1'b0;
      checkEq("midrst busy", busyA, 0);
      checkEq("midrst hash_start", hsA, 0);
      checkEq("midrst current_nonce", cnA, 0);
      checkEq("midrst header", headerA, 0);
      step();
      checkEq("midrst no pulse", hsA, 0);

      // Sweep with hit on nonce 3, checking the two-cycle reissue cadence
      target = 256'hFF;
      pulsesA = 0;
      start = 1'b1; step(); start = 1'b0;
      for (int n = 0; n < 4; n++) begin
         serve(1'b0, (n == 3) ? HIT1 : MISS, seen);
         checkEq("nonce in header", seen, n);
         if (n < 3) begin
            checkEq("no pulse in check", hsA, 0);
            step();
            checkEq("reissue at t+2", hsA, 1);
            checkEq("header next nonce", headerA[31:0], n + 1);
         end
      end
      step();
      checkEq("hit found", foundA, 1);
      checkEq("hit found_nonce", fnA, 3);
      checkEq("hit header nonce", headerA[31:0], 3);
      checkEq("hit header template", headerA[639:32], tmpl[639:32]);
      checkEq("hit busy", busyA, 0);
      checkEq("hit pulses", pulsesA, 4);
      hash = HIT1; hashValidA = 1'b1; step(); hashValidA = 1'b0;
      step(); step();
      checkEq("done hold found", foundA, 1);
      checkEq("done hold nonce", fnA, 3);
      checkEq("done hold pulses", pulsesA, 4);

      // Boundary: reversed hash equal to target is a hit
      start = 1'b1; step(); start = 1'b0;
      checkEq("start clears found", foundA, 0);
      serve(1'b0, EQFF, seen);
      step();
      checkEq("equal found", foundA, 1);
      checkEq("equal found_nonce", fnA, 0);

      // Boundary: target+1 misses and the sweep continues
      start = 1'b1; step(); start = 1'b0;
      serve(1'b0, PLUS1, seen);
      checkEq("plus1 no found", foundA, 0);
      step();
      checkEq("plus1 reissue", hsA, 1);
      checkEq("plus1 current_nonce", cnA, 1);

      // Abort in the same cycle as a winning hash_valid
      step(); step();
      hash = HIT1; hashValidA = 1'b1; abort = 1'b1;
      step();
      hashValidA = 1'b0; abort = 1'b0;
      checkEq("abort busy", busyA, 0);
      checkEq("abort hash_start", hsA, 0);
      checkEq("abort found", foundA, 0);
      step(); step();
      checkEq("abort stays idle", busyA, 0);
      checkEq("abort hash discarded", foundA, 0);

      // Range exhaustion at the top of the 32-bit space
      rst = 1'b1; step(); rst = 1'b0;
      target = '0;
      pulsesB = 0;
      start = 1'b1; step(); start = 1'b0;
      serve(1'b1, MISS, seen);
      checkEq("exh first nonce", seen, 32'hFFFF_FFFE);
      step();
      serve(1'b1, MISS, seen);
      checkEq("exh last nonce", seen, 32'hFFFF_FFFF);
      step();
      checkEq("exh exhausted", exhB, 1);
      checkEq("exh found", foundB, 0);
      checkEq("exh current_nonce", cnB, 32'hFFFF_FFFF);
      checkEq("exh busy", busyB, 0);
      step(); step(); step(); step();
      checkEq("exh pulses", pulsesB, 2);
      checkEq("exh no wrap", cnB, 32'hFFFF_FFFF);
      abort = 1'b1; step(); abort = 1'b0;
      checkEq("abort clears exhausted", exhB, 0);

`ifdef HASH_TIMEOUT_EN
      rst = 1'b1; step(); rst = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step();
      for (int i = 0; i < 15; i++) step();
      checkEq("timeout not early", toA, 0);
      step();
      checkEq("timeout fired", toA, 1);
      checkEq("timeout found", foundA, 0);
      checkEq("timeout exhausted", exhA, 0);
      checkEq("timeout busy", busyA, 0);
      checkEq("timeout stalled nonce", cnA, 0);
`else
      checkEq("timeout tied A", toA, 0);
      checkEq("timeout tied B", toB, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
